// File: rtl/issueq_dispatch_ctrl_if.sv
// Dispatch-side bus bundle between the rename/dispatch stage, free list, select logic
// and the issue-queue payload array, as seen by issueq_dispatch_ctrl.
interface issueq_dispatch_ctrl_if #(
   parameter int unsigned SIZE_ISSUEQ     = 32,
   parameter int unsigned SIZE_ISSUEQ_LOG = 5,
   parameter int unsigned PAYLOAD_W       = 64
);
   logic                        bundleValid_i;
   logic [4*PAYLOAD_W-1:0]      bundlePayload_i;
   logic                        stallUpstream_o;
   logic [SIZE_ISSUEQ_LOG:0]    cntInstIssueQ_i;
   logic [SIZE_ISSUEQ_LOG-1:0]  freeEntry0_i;
   logic [SIZE_ISSUEQ_LOG-1:0]  freeEntry1_i;
   logic [SIZE_ISSUEQ_LOG-1:0]  freeEntry2_i;
   logic [SIZE_ISSUEQ_LOG-1:0]  freeEntry3_i;
   logic                        backEndReady_o;
   logic [SIZE_ISSUEQ_LOG-1:0]  grantedEntry0_i;
   logic [SIZE_ISSUEQ_LOG-1:0]  grantedEntry1_i;
   logic [SIZE_ISSUEQ_LOG-1:0]  grantedEntry2_i;
   logic [SIZE_ISSUEQ_LOG-1:0]  grantedEntry3_i;
   logic                        grantedValid0_i;
   logic                        grantedValid1_i;
   logic                        grantedValid2_i;
   logic                        grantedValid3_i;
   logic                        ctrlMispredict_i;
   logic [SIZE_ISSUEQ-1:0]      mispredictVector_i;
   logic                        iqWrEn_o;
   logic [SIZE_ISSUEQ_LOG-1:0]  iqWrIndex0_o;
   logic [SIZE_ISSUEQ_LOG-1:0]  iqWrIndex1_o;
   logic [SIZE_ISSUEQ_LOG-1:0]  iqWrIndex2_o;
   logic [SIZE_ISSUEQ_LOG-1:0]  iqWrIndex3_o;
   logic [4*PAYLOAD_W-1:0]      iqWrData_o;
   logic [SIZE_ISSUEQ-1:0]      iqValidVector_o;

   modport master (
      output bundleValid_i, bundlePayload_i, cntInstIssueQ_i,
             freeEntry0_i, freeEntry1_i, freeEntry2_i, freeEntry3_i,
             grantedEntry0_i, grantedEntry1_i, grantedEntry2_i, grantedEntry3_i,
             grantedValid0_i, grantedValid1_i, grantedValid2_i, grantedValid3_i,
             ctrlMispredict_i, mispredictVector_i,
      input  stallUpstream_o, backEndReady_o, iqWrEn_o,
             iqWrIndex0_o, iqWrIndex1_o, iqWrIndex2_o, iqWrIndex3_o,
             iqWrData_o, iqValidVector_o
   );

   modport slave (
      input  bundleValid_i, bundlePayload_i, cntInstIssueQ_i,
             freeEntry0_i, freeEntry1_i, freeEntry2_i, freeEntry3_i,
             grantedEntry0_i, grantedEntry1_i, grantedEntry2_i, grantedEntry3_i,
             grantedValid0_i, grantedValid1_i, grantedValid2_i, grantedValid3_i,
             ctrlMispredict_i, mispredictVector_i,
      output stallUpstream_o, backEndReady_o, iqWrEn_o,
             iqWrIndex0_o, iqWrIndex1_o, iqWrIndex2_o, iqWrIndex3_o,
             iqWrData_o, iqValidVector_o
   );
endinterface

// File: rtl/issueq_dispatch_ctrl.sv
// Issue-queue dispatch control: holds one dispatch bundle, allocates free-list entries,
// writes the payload array and tracks per-entry valid bits with a post-mispredict flush window.
module issueq_dispatch_ctrl #(
   parameter int unsigned SIZE_ISSUEQ     = 32,
   parameter int unsigned SIZE_ISSUEQ_LOG = 5,
   parameter int unsigned DISPATCH_WIDTH  = 4,
   parameter int unsigned ISSUE_WIDTH     = 4,
   parameter int unsigned PAYLOAD_W       = 64,
   parameter int unsigned FLUSH_CYCLES    = 2
) (
   input logic                   clk,
   input logic                   reset,
   issueq_dispatch_ctrl_if.slave bus
);
   localparam int unsigned IDX_W    = SIZE_ISSUEQ_LOG;
   localparam int unsigned OCC_W    = SIZE_ISSUEQ_LOG + 2;
   localparam int unsigned BUNDLE_W = DISPATCH_WIDTH * PAYLOAD_W;
   localparam int unsigned CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic {
      S_RUN   = 1'b0,
      S_FLUSH = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
   logic                  bundle_vld_q, bundle_vld_d;
   logic [BUNDLE_W-1:0]   bundle_q, bundle_d;
   logic                  wr_en_q, wr_en_d;
   logic [IDX_W-1:0]      wr_idx_q [DISPATCH_WIDTH];
   logic [IDX_W-1:0]      wr_idx_d [DISPATCH_WIDTH];
   logic [BUNDLE_W-1:0]   wr_data_q, wr_data_d;
   logic [SIZE_ISSUEQ-1:0] valid_vec_q, valid_vec_d;

   logic [IDX_W-1:0]      free_idx [DISPATCH_WIDTH];
   logic [IDX_W-1:0]      gnt_idx  [ISSUE_WIDTH];
   logic                  gnt_vld  [ISSUE_WIDTH];
   logic                  space_c;
   logic                  ready_c;
   logic                  stall_c;
   logic [SIZE_ISSUEQ-1:0] set_mask, gnt_mask, squash_mask;

   assign free_idx[0] = bus.freeEntry0_i;
   assign free_idx[1] = bus.freeEntry1_i;
   assign free_idx[2] = bus.freeEntry2_i;
   assign free_idx[3] = bus.freeEntry3_i;
   assign gnt_idx[0]  = bus.grantedEntry0_i;
   assign gnt_idx[1]  = bus.grantedEntry1_i;
   assign gnt_idx[2]  = bus.grantedEntry2_i;
   assign gnt_idx[3]  = bus.grantedEntry3_i;
   assign gnt_vld[0]  = bus.grantedValid0_i;
   assign gnt_vld[1]  = bus.grantedValid1_i;
   assign gnt_vld[2]  = bus.grantedValid2_i;
   assign gnt_vld[3]  = bus.grantedValid3_i;

   // Handshake: entries freed this cycle are deliberately not credited to the space check
   always_comb begin
      space_c = (OCC_W'(bus.cntInstIssueQ_i) + OCC_W'(DISPATCH_WIDTH)) <= OCC_W'(SIZE_ISSUEQ);
      ready_c = (state_q == S_RUN) & bundle_vld_q & space_c & ~bus.ctrlMispredict_i;
      stall_c = (state_q != S_RUN) | bus.ctrlMispredict_i | (bundle_vld_q & ~ready_c);
   end

   assign bus.backEndReady_o  = ready_c;
   assign bus.stallUpstream_o = stall_c;

   // Next-state: flush FSM, bundle register, write port and valid vector
   always_comb begin
      state_d      = state_q;
      flush_cnt_d  = flush_cnt_q;
      bundle_vld_d = bundle_vld_q;
      bundle_d     = bundle_q;
      wr_en_d      = ready_c;
      wr_idx_d     = wr_idx_q;
      wr_data_d    = wr_data_q;
      set_mask     = '0;
      gnt_mask     = '0;
      squash_mask  = '0;

      case (state_q)
         S_RUN: begin
            if (bus.ctrlMispredict_i) begin
               state_d     = S_FLUSH;
               flush_cnt_d = CNT_W'(FLUSH_CYCLES - 1);
            end
         end
         S_FLUSH: begin
            if (bus.ctrlMispredict_i) begin
               flush_cnt_d = CNT_W'(FLUSH_CYCLES - 1);
            end else if (flush_cnt_q == '0) begin
               state_d = S_RUN;
            end else begin
               flush_cnt_d = flush_cnt_q - CNT_W'(1);
            end
         end
         default: state_d = S_RUN;
      endcase

      // Wrong-path bundle is discarded; load and drain may coincide for full throughput
      if (bus.ctrlMispredict_i) begin
         bundle_vld_d = 1'b0;
      end else if (bus.bundleValid_i && !stall_c) begin
         bundle_vld_d = 1'b1;
         bundle_d     = bus.bundlePayload_i;
      end else if (ready_c) begin
         bundle_vld_d = 1'b0;
      end

      if (ready_c) begin
         wr_data_d = bundle_q;
         for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            wr_idx_d[i]           = free_idx[i];
            set_mask[free_idx[i]] = 1'b1;
         end
      end

      for (int j = 0; j < ISSUE_WIDTH; j++) begin
         if (gnt_vld[j]) gnt_mask[gnt_idx[j]] = 1'b1;
      end
      if (bus.ctrlMispredict_i) squash_mask = bus.mispredictVector_i;

      valid_vec_d = (valid_vec_q | set_mask) & ~gnt_mask & ~squash_mask;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_RUN;
         flush_cnt_q  <= '0;
         bundle_vld_q <= 1'b0;
         bundle_q     <= '0;
         wr_en_q      <= 1'b0;
         for (int i = 0; i < DISPATCH_WIDTH; i++) wr_idx_q[i] <= '0;
         wr_data_q    <= '0;
         valid_vec_q  <= '0;
      end else begin
         state_q      <= state_d;
         flush_cnt_q  <= flush_cnt_d;
         bundle_vld_q <= bundle_vld_d;
         bundle_q     <= bundle_d;
         wr_en_q      <= wr_en_d;
         wr_idx_q     <= wr_idx_d;
         wr_data_q    <= wr_data_d;
         valid_vec_q  <= valid_vec_d;
      end
   end

   assign bus.iqWrEn_o        = wr_en_q;
   assign bus.iqWrIndex0_o    = wr_idx_q[0];
   assign bus.iqWrIndex1_o    = wr_idx_q[1];
   assign bus.iqWrIndex2_o    = wr_idx_q[2];
   assign bus.iqWrIndex3_o    = wr_idx_q[3];
   assign bus.iqWrData_o      = wr_data_q;
   assign bus.iqValidVector_o = valid_vec_q;
endmodule

// File: tb/tb_issueq_dispatch_ctrl.sv
// Directed bench for issueq_dispatch_ctrl: stimulus pushes expected payload-array writes,
// a negedge monitor pops and compares them whenever iqWrEn_o is seen.
module tb_issueq_dispatch_ctrl;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   issueq_dispatch_ctrl_if #(.SIZE_ISSUEQ(32), .SIZE_ISSUEQ_LOG(5), .PAYLOAD_W(64)) bus ();

   issueq_dispatch_ctrl #(
      .SIZE_ISSUEQ(32), .SIZE_ISSUEQ_LOG(5), .DISPATCH_WIDTH(4),
      .ISSUE_WIDTH(4), .PAYLOAD_W(64), .FLUSH_CYCLES(2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [19:0]  idx;   // {idx3, idx2, idx1, idx0}
      logic [255:0] data;
      logic [31:0]  vec;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   tests_run    = 0;
   int   tests_failed = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      tests_run++;
      if (act !== req) begin
         tests_failed++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   function automatic logic [255:0] mkp(input logic [15:0] tag);
      return {tag, 48'd3, tag, 48'd2, tag, 48'd1, tag, 48'd0};
   endfunction

   task automatic push(input logic [19:0] idx, input logic [255:0] data, input logic [31:0] vec);
      exp_t e;
      e.idx  = idx;
      e.data = data;
      e.vec  = vec;
      exp_q.push_back(e);
   endtask

   task automatic set_free(input logic [19:0] f);
      bus.freeEntry0_i = f[4:0];
      bus.freeEntry1_i = f[9:5];
      bus.freeEntry2_i = f[14:10];
      bus.freeEntry3_i = f[19:15];
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (bus.iqWrEn_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_write: iqWrEn_o=1, required no pending allocation");
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_idx", 64'({bus.iqWrIndex3_o, bus.iqWrIndex2_o, bus.iqWrIndex1_o, bus.iqWrIndex0_o}),
                64'(mon_e.idx));
            tests_run++;
            if (bus.iqWrData_o !== mon_e.data) begin
               tests_failed++;
               $display("FAIL wr_data: got %h, required %h", bus.iqWrData_o, mon_e.data);
            end
            chk("wr_vec", 64'(bus.iqValidVector_o), 64'(mon_e.vec));
         end
      end
   end

   // Free list must never offer duplicates or an entry being granted in the same cycle
   always @(negedge clk) begin
      if (reset === 1'b1 && bus.backEndReady_o === 1'b1) begin
         assert (bus.freeEntry0_i != bus.freeEntry1_i && bus.freeEntry0_i != bus.freeEntry2_i &&
                 bus.freeEntry0_i != bus.freeEntry3_i && bus.freeEntry1_i != bus.freeEntry2_i &&
                 bus.freeEntry1_i != bus.freeEntry3_i && bus.freeEntry2_i != bus.freeEntry3_i)
            else $error("duplicate free entries offered");
         for (int k = 0; k < 4; k++) begin
            logic [4:0] f;
            f = (k == 0) ? bus.freeEntry0_i : (k == 1) ? bus.freeEntry1_i :
                (k == 2) ? bus.freeEntry2_i : bus.freeEntry3_i;
            assert (!((bus.grantedValid0_i && bus.grantedEntry0_i == f) ||
                      (bus.grantedValid1_i && bus.grantedEntry1_i == f) ||
                      (bus.grantedValid2_i && bus.grantedEntry2_i == f) ||
                      (bus.grantedValid3_i && bus.grantedEntry3_i == f)))
               else $error("allocation onto granted entry %0d", f);
         end
      end
   end

   logic [19:0]  t3_free [4];
   logic [31:0]  t3_vec  [4];
   logic [255:0] t3_pay  [4];

   initial begin
      t3_free = '{{5'd20, 5'd19, 5'd18, 5'd17}, {5'd24, 5'd23, 5'd22, 5'd21},
                  {5'd28, 5'd27, 5'd26, 5'd25}, {5'd0, 5'd31, 5'd30, 5'd29}};
      t3_vec  = '{32'h001F_FFE0, 32'h01FF_FFE0, 32'h1FFF_FFE0, 32'hFFFF_FFE1};
      for (int i = 0; i < 4; i++) t3_pay[i] = mkp(16'h4A00 + 16'(i));

      // Reset held with a bundle offered
      reset                  = 1'b0;
      bus.bundleValid_i      = 1'b1;
      bus.bundlePayload_i    = mkp(16'h1111);
      bus.cntInstIssueQ_i    = '0;
      set_free({5'd8, 5'd7, 5'd6, 5'd5});
      bus.grantedEntry0_i    = '0; bus.grantedEntry1_i = '0;
      bus.grantedEntry2_i    = '0; bus.grantedEntry3_i = '0;
      bus.grantedValid0_i    = 1'b0; bus.grantedValid1_i = 1'b0;
      bus.grantedValid2_i    = 1'b0; bus.grantedValid3_i = 1'b0;
      bus.ctrlMispredict_i   = 1'b0;
      bus.mispredictVector_i = '0;
      #22;
      chk("rst_ready", 64'(bus.backEndReady_o), 64'd0);
      chk("rst_stall", 64'(bus.stallUpstream_o), 64'd0);
      chk("rst_wren", 64'(bus.iqWrEn_o), 64'd0);
      chk("rst_vec", 64'(bus.iqValidVector_o), 64'd0);
      chk("rst_idx0", 64'(bus.iqWrIndex0_o), 64'd0);
      chk("rst_data", 64'(bus.iqWrData_o != '0), 64'd0);

      // First allocation after release
      reset = 1'b1;
      cyc();
      bus.bundleValid_i = 1'b0;
      #1;
      chk("first_ready", 64'(bus.backEndReady_o), 64'd1);
      chk("first_stall", 64'(bus.stallUpstream_o), 64'd0);
      push({5'd8, 5'd7, 5'd6, 5'd5}, mkp(16'h1111), 32'h0000_01E0);
      cyc();
      chk("drained_ready", 64'(bus.backEndReady_o), 64'd0);

      // Occupancy boundary: 28 fits, 29 does not
      bus.cntInstIssueQ_i = 6'd28;
      set_free({5'd12, 5'd11, 5'd10, 5'd9});
      bus.bundleValid_i   = 1'b1;
      bus.bundlePayload_i = mkp(16'h2222);
      cyc();
      bus.bundleValid_i = 1'b0;
      #1;
      chk("cnt28_ready", 64'(bus.backEndReady_o), 64'd1);
      push({5'd12, 5'd11, 5'd10, 5'd9}, mkp(16'h2222), 32'h0000_1FE0);
      cyc();
      bus.cntInstIssueQ_i = 6'd29;
      set_free({5'd16, 5'd15, 5'd14, 5'd13});
      bus.bundleValid_i   = 1'b1;
      bus.bundlePayload_i = mkp(16'h3333);
      cyc();
      bus.bundleValid_i = 1'b0;
      #1;
      chk("cnt29_ready", 64'(bus.backEndReady_o), 64'd0);
      chk("cnt29_stall", 64'(bus.stallUpstream_o), 64'd1);
      cyc();
      chk("cnt29_hold_ready", 64'(bus.backEndReady_o), 64'd0);
      chk("cnt29_hold_stall", 64'(bus.stallUpstream_o), 64'd1);
      chk("cnt29_no_wren", 64'(bus.iqWrEn_o), 64'd0);
      bus.cntInstIssueQ_i = 6'd28;
      #1;
      chk("cnt28_resume", 64'(bus.backEndReady_o), 64'd1);
      push({5'd16, 5'd15, 5'd14, 5'd13}, mkp(16'h3333), 32'h0001_FFE0);
      cyc();

      // Back-to-back bundles at one per cycle
      bus.cntInstIssueQ_i = '0;
      bus.bundleValid_i   = 1'b1;
      bus.bundlePayload_i = t3_pay[0];
      cyc();
      for (int i = 0; i < 4; i++) begin
         if (i < 3) bus.bundlePayload_i = t3_pay[i + 1];
         else       bus.bundleValid_i = 1'b0;
         set_free(t3_free[i]);
         #1;
         chk("stream_ready", 64'(bus.backEndReady_o), 64'd1);
         chk("stream_stall", 64'(bus.stallUpstream_o), 64'd0);
         push(t3_free[i], t3_pay[i], t3_vec[i]);
         cyc();
      end
      chk("stream_end_ready", 64'(bus.backEndReady_o), 64'd0);
      cyc();

      // Reset pulse, then populate entries 0..3
      reset = 1'b0;
      #1;
      chk("pulse_vec", 64'(bus.iqValidVector_o), 64'd0);
      reset = 1'b1;
      bus.bundleValid_i   = 1'b1;
      bus.bundlePayload_i = mkp(16'h5555);
      set_free({5'd3, 5'd2, 5'd1, 5'd0});
      cyc();
      bus.bundleValid_i = 1'b0;
      #1;
      chk("low_ready", 64'(bus.backEndReady_o), 64'd1);
      push({5'd3, 5'd2, 5'd1, 5'd0}, mkp(16'h5555), 32'h0000_000F);
      cyc();

      // Mispredict with a held bundle, grants and squash in the same cycle
      bus.bundleValid_i   = 1'b1;
      bus.bundlePayload_i = mkp(16'h6666);
      bus.cntInstIssueQ_i = 6'd29;
      cyc();
      bus.bundleValid_i = 1'b0;
      #1;
      chk("held_stall", 64'(bus.stallUpstream_o), 64'd1);
      bus.ctrlMispredict_i   = 1'b1;
      bus.mispredictVector_i = 32'h0000_0009;
      bus.grantedEntry0_i    = 5'd2; bus.grantedValid0_i = 1'b1;
      bus.grantedEntry1_i    = 5'd1; bus.grantedValid1_i = 1'b1;
      bus.cntInstIssueQ_i    = '0;
      #1;
      chk("mp_ready", 64'(bus.backEndReady_o), 64'd0);
      chk("mp_stall", 64'(bus.stallUpstream_o), 64'd1);
      cyc();
      bus.ctrlMispredict_i   = 1'b0;
      bus.mispredictVector_i = '0;
      bus.grantedValid0_i    = 1'b0;
      bus.grantedValid1_i    = 1'b0;
      bus.bundleValid_i      = 1'b1;
      bus.bundlePayload_i    = mkp(16'h7777);
      set_free({5'd7, 5'd6, 5'd5, 5'd4});
      #1;
      chk("mp_vec", 64'(bus.iqValidVector_o), 64'd0);
      chk("flush1_stall", 64'(bus.stallUpstream_o), 64'd1);
      chk("flush1_ready", 64'(bus.backEndReady_o), 64'd0);
      cyc();
      chk("flush2_stall", 64'(bus.stallUpstream_o), 64'd1);
      chk("flush2_ready", 64'(bus.backEndReady_o), 64'd0);
      cyc();
      chk("run_stall", 64'(bus.stallUpstream_o), 64'd0);
      chk("run_dropped", 64'(bus.backEndReady_o), 64'd0);
      cyc();
      bus.bundleValid_i = 1'b0;
      #1;
      chk("resume_ready", 64'(bus.backEndReady_o), 64'd1);
      push({5'd7, 5'd6, 5'd5, 5'd4}, mkp(16'h7777), 32'h0000_00F0);
      cyc();

      // Mispredict again during the second flush cycle reloads the window
      chk("idle_ready", 64'(bus.backEndReady_o), 64'd0);
      bus.ctrlMispredict_i = 1'b1;
      cyc();
      bus.ctrlMispredict_i = 1'b0;
      #1;
      chk("re_f1_stall", 64'(bus.stallUpstream_o), 64'd1);
      cyc();
      bus.ctrlMispredict_i = 1'b1;
      #1;
      chk("re_f2_stall", 64'(bus.stallUpstream_o), 64'd1);
      cyc();
      bus.ctrlMispredict_i = 1'b0;
      #1;
      chk("re_f3_stall", 64'(bus.stallUpstream_o), 64'd1);
      cyc();
      chk("re_f4_stall", 64'(bus.stallUpstream_o), 64'd1);
      cyc();
      chk("re_run_stall", 64'(bus.stallUpstream_o), 64'd0);
      chk("re_vec", 64'(bus.iqValidVector_o), 64'h0000_00F0);

      // Asynchronous reset in the middle of a flush window
      bus.ctrlMispredict_i = 1'b1;
      cyc();
      bus.ctrlMispredict_i = 1'b0;
      #1;
      chk("ar_flush_stall", 64'(bus.stallUpstream_o), 64'd1);
      reset = 1'b0;
      #1;
      chk("ar_stall", 64'(bus.stallUpstream_o), 64'd0);
      chk("ar_vec", 64'(bus.iqValidVector_o), 64'd0);
      chk("ar_idx", 64'({bus.iqWrIndex3_o, bus.iqWrIndex2_o, bus.iqWrIndex1_o, bus.iqWrIndex0_o}), 64'd0);
      chk("ar_data", 64'(bus.iqWrData_o != '0), 64'd0);
      chk("ar_wren", 64'(bus.iqWrEn_o), 64'd0);
      reset = 1'b1;
      bus.bundleValid_i   = 1'b1;
      bus.bundlePayload_i = mkp(16'h8888);
      set_free({5'd12, 5'd11, 5'd10, 5'd9});
      cyc();
      bus.bundleValid_i = 1'b0;
      #1;
      chk("ar_run_stall", 64'(bus.stallUpstream_o), 64'd0);
      chk("ar_run_ready", 64'(bus.backEndReady_o), 64'd1);
      push({5'd12, 5'd11, 5'd10, 5'd9}, mkp(16'h8888), 32'h0000_1E00);
      cyc();
      cyc();
      chk("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
